iopad_ctrl: RTL and testbench

//  Per-bank controller sitting directly upstream of an array of NUM_IO iopad cells.
//  - Drives each pad's direction, zin and dout; consumes each pad's din.
//  - A serial configuration chain programs the direction bits.
//  - All pads are held tristated (direction=1) until a complete configuration has loaded.
//  - Registers the fabric->pad outputs and synchronises the pad->fabric inputs.

---
 rtl/iopad_ctrl.sv | 104 ++++++++++
 tb/tb_iopad_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/iopad_ctrl.sv
// Per-bank iopad controller: serial direction-config chain, registered pad outputs, masked
// pad input capture. Define IOPAD_CTRL_INPUT_SYNC_EN for a 2-flop input synchroniser.
module iopad_ctrl #(
  parameter int unsigned NUM_IO = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_en,
  input  logic              prog_in,
  output logic              prog_out,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic [NUM_IO-1:0] core_out,
  output logic [NUM_IO-1:0] core_in,
  output logic [NUM_IO-1:0] pad_dout,
  input  logic [NUM_IO-1:0] pad_din,
  output logic [NUM_IO-1:0] pad_direction,
  output logic [NUM_IO-1:0] pad_zin
);

  localparam int unsigned CW = $clog2(NUM_IO + 1);
  localparam logic [CW-1:0] CntMax = CW'(NUM_IO);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q;
  logic [NUM_IO-1:0] cfg_sr_q;
  logic [NUM_IO-1:0] cfg_active_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [NUM_IO-1:0] sr_shifted;
  logic [NUM_IO-1:0] in_mask;
  logic              done;

  assign done = (state_q == StDone);

  // Shift-left form stays legal for NUM_IO == 1.
  always_comb begin
    sr_shifted    = cfg_sr_q << 1;
    sr_shifted[0] = prog_in;
  end

  // Mask before the first capture flop so an undriven pad never reaches the fabric.
  assign in_mask       = done ? cfg_active_q : '0;
  assign cfg_done      = done;
  assign pad_direction = done ? cfg_active_q : '1;
  assign pad_zin       = pad_direction;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cfg_sr_q     <= '0;
      cfg_active_q <= '1;
      bit_cnt_q    <= '0;
      prog_out     <= 1'b0;
      cfg_err      <= 1'b0;
      pad_dout     <= '0;
    end else begin
      pad_dout <= done ? (core_out & ~cfg_active_q) : '0;
      if (prog_en) begin
        state_q  <= StShift;
        cfg_sr_q <= sr_shifted;
        prog_out <= cfg_sr_q[NUM_IO-1];
        if (state_q != StShift) begin
          bit_cnt_q <= CW'(1);
        end else if (bit_cnt_q != CntMax) begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
        end
      end else if (state_q == StShift) begin
        if (bit_cnt_q == CntMax) begin
          state_q      <= StDone;
          cfg_active_q <= cfg_sr_q;
          cfg_err      <= 1'b0;
        end else begin
          state_q   <= StIdle;
          bit_cnt_q <= '0;
          cfg_err   <= 1'b1;
        end
      end
    end
  end

`ifdef IOPAD_CTRL_INPUT_SYNC_EN
  logic [NUM_IO-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= '0;
      core_in <= '0;
    end else begin
      meta_q  <= pad_din & in_mask;
      core_in <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_in <= '0;
    end else begin
      core_in <= pad_din & in_mask;
    end
  end
`endif

endmodule

// File: tb/tb_iopad_ctrl.sv
// Self-checking bench for iopad_ctrl (NUM_IO=8): vector table with a scoreboard queue for the
// data path, plus hand-written sequences for config loading, errors and reset.
module tb_iopad_ctrl;

`ifdef IOPAD_CTRL_INPUT_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_en, prog_in, prog_out, cfg_done, cfg_err;
  logic [7:0] core_out, core_in, pad_dout, pad_din, pad_direction, pad_zin;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] cfg;
    logic [7:0] core_out;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic [7:0] exp_cin;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] dout;
    logic [7:0] cin;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  iopad_ctrl #(.NUM_IO(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .prog_en      (prog_en),
    .prog_in      (prog_in),
    .prog_out     (prog_out),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .core_out     (core_out),
    .core_in      (core_in),
    .pad_dout     (pad_dout),
    .pad_din      (pad_din),
    .pad_direction(pad_direction),
    .pad_zin      (pad_zin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dir"},  16'(pad_direction), 16'hFF);
    chk({tag, "_zin"},  16'(pad_zin),       16'hFF);
    chk({tag, "_dout"}, 16'(pad_dout),      16'h00);
    chk({tag, "_cin"},  16'(core_in),       16'h00);
    chk({tag, "_done"}, 16'(cfg_done),      16'h0);
    chk({tag, "_err"},  16'(cfg_err),       16'h0);
    chk({tag, "_pout"}, 16'(prog_out),      16'h0);
  endtask

  // Shift n bits MSB-first, drop prog_en, and return after the terminating edge.
  task automatic load(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      prog_en = 1'b1;
      prog_in = bits[i];
    end
    @(negedge clk);
    prog_en = 1'b0;
    prog_in = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] stream;
    logic [9:0]  recfg;
    exp_t        e;

    vecs[0] = '{8'hA5, 8'hFF, 8'hFF, 8'h5A, 8'hA5};
    vecs[1] = '{8'h0F, 8'h33, 8'hCC, 8'h30, 8'h0C};
    vecs[2] = '{8'h00, 8'hA5, 8'hFF, 8'hA5, 8'h00};
    vecs[3] = '{8'hFF, 8'hFF, 8'h5A, 8'h00, 8'h5A};
    vecs[4] = '{8'h3C, 8'h96, 8'h69, 8'h82, 8'h28};
    vecs[5] = '{8'h81, 8'h7E, 8'h81, 8'h7E, 8'h81};

    rst_n = 1'b0; prog_en = 1'b0; prog_in = 1'b0; core_out = '0; pad_din = '0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;

    // Unconfigured: outputs and inputs blocked.
    core_out = 8'hFF; pad_din = 8'hFF;
    repeat (3) @(negedge clk);
    chk("idle_dout", 16'(pad_dout), 16'h00);
    chk("idle_cin",  16'(core_in),  16'h00);
    core_out = '0; pad_din = '0;

    // Plain 8-bit load of A5.
    load(16'h00A5, 8);
    chk("a5_done", 16'(cfg_done),      16'h1);
    chk("a5_dir",  16'(pad_direction), 16'hA5);
    chk("a5_zin",  16'(pad_zin),       16'hA5);
    chk("a5_err",  16'(cfg_err),       16'h0);

    // Latency check: dout after 1 edge, core_in after Lat edges.
    @(negedge clk);
    core_out = 8'hFF; pad_din = 8'hFF;
    @(negedge clk);
    chk("lat1_dout", 16'(pad_dout), 16'h5A);
    chk("lat1_cin",  16'(core_in),  (Lat == 1) ? 16'hA5 : 16'h00);
    @(negedge clk);
    chk("lat2_cin",  16'(core_in),  16'hA5);
    core_out = '0; pad_din = '0;

    // Table-driven data path, scoreboarded.
    foreach (vecs[v]) begin
      load(16'(vecs[v].cfg), 8);
      chk($sformatf("vec%0d_dir", v), 16'(pad_direction), 16'(vecs[v].cfg));
      core_out = vecs[v].core_out;
      pad_din  = vecs[v].din;
      sb.push_back('{$sformatf("vec%0d", v), vecs[v].exp_dout, vecs[v].exp_cin});
      repeat (Lat) @(negedge clk);
      e = sb.pop_front();
      chk({e.name, "_dout"}, 16'(pad_dout), 16'(e.dout));
      chk({e.name, "_cin"},  16'(core_in),  16'(e.cin));
    end

    // Async reset mid-operation.
    core_out = 8'hFF; pad_din = 8'hFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_op");
    core_out = '0; pad_din = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous 16-bit stream: prog_out replays earlier bits, last 8 bits win.
    stream = 16'h5AA5;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j >= 1) chk($sformatf("pout_e%0d", j), 16'(prog_out),
                      (j >= 9) ? 16'(stream[24 - j]) : 16'h0);
      prog_en = 1'b1;
      prog_in = stream[15 - j];
    end
    @(negedge clk);
    chk("pout_e16", 16'(prog_out), 16'(stream[8]));
    prog_en = 1'b0; prog_in = 1'b0;
    @(negedge clk);
    chk("long_done", 16'(cfg_done),      16'h1);
    chk("long_dir",  16'(pad_direction), 16'hA5);

    // Short load from DONE: error, tristated, old config not applied.
    load(16'h0016, 5);
    chk("short_err",  16'(cfg_err),       16'h1);
    chk("short_done", 16'(cfg_done),      16'h0);
    chk("short_dir",  16'(pad_direction), 16'hFF);
    core_out = 8'hFF; pad_din = 8'hFF;
    repeat (Lat + 1) @(negedge clk);
    chk("short_dout", 16'(pad_dout), 16'h00);
    chk("short_cin",  16'(core_in),  16'h00);
    core_out = '0; pad_din = '0;
    load(16'h000F, 8);
    chk("fix_err",  16'(cfg_err),       16'h0);
    chk("fix_done", 16'(cfg_done),      16'h1);
    chk("fix_dir",  16'(pad_direction), 16'h0F);

    // Reset after 4 shifted bits, then a fresh load.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      prog_en = 1'b1;
      prog_in = i[0];
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    prog_en = 1'b0; prog_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load(16'h00C3, 8);
    chk("fresh_done", 16'(cfg_done),      16'h1);
    chk("fresh_dir",  16'(pad_direction), 16'hC3);
    chk("fresh_err",  16'(cfg_err),       16'h0);

    // Reconfigure from DONE with 10 bits; pads tristate on the first shift edge.
    core_out = 8'hFF;
    @(negedge clk);
    chk("pre_dout", 16'(pad_dout), 16'h3C);
    recfg = 10'h33C;
    prog_en = 1'b1; prog_in = recfg[9]; core_out = 8'h00;
    @(negedge clk);
    chk("recfg_done", 16'(cfg_done),      16'h0);
    chk("recfg_dir",  16'(pad_direction), 16'hFF);
    chk("recfg_dout", 16'(pad_dout),      16'h00);
    core_out = 8'hFF;
    for (int i = 8; i >= 0; i--) begin
      prog_in = recfg[i];
      @(negedge clk);
      if (i == 8) chk("recfg_dout2", 16'(pad_dout), 16'h00);
    end
    prog_en = 1'b0; prog_in = 1'b0;
    @(negedge clk);
    chk("recfg_final_done", 16'(cfg_done),      16'h1);
    chk("recfg_final_dir",  16'(pad_direction), 16'h3C);
    core_out = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
